// File: rtl/multi_edge_sync.sv
// -----------------------------------------------------------------------------
// multi_edge_sync
//   Brings CHANNELS asynchronous level signals into the rd_clk domain through a
//   SYNC_STAGES-deep flop chain, optionally filters them (a synced change must
//   persist for FILTER_LEN consecutive rd_clk edges before it is accepted),
//   reports accepted rising/falling edges and counts the edges selected by
//   edge_mode in per-channel saturating counters with a sticky overflow flag.
//
// Ports
//   rd_clk      in   rd-domain clock
//   rd_reset    in   asynchronous active-low reset
//   async_in    in   [CHANNELS]        foreign-domain level inputs (register driven)
//   edge_mode   in   [2*CHANNELS]      per channel {fall_en, rise_en} at [2c+1:2c]
//   cnt_clr     in   [CHANNELS]        per-channel counter/overflow clear pulse
//   level_o     out  [CHANNELS]        accepted (synced + filtered) level
//   rise_o      out  [CHANNELS]        one-cycle pulse on accepted 0->1
//   fall_o      out  [CHANNELS]        one-cycle pulse on accepted 1->0
//   event_o     out  [CHANNELS]        edges selected by edge_mode
//   evt_cnt_o   out  [CHANNELS*CNT_W]  channel c count at [c*CNT_W +: CNT_W]
//   overflow_o  out  [CHANNELS]        sticky: event seen while counter saturated
// -----------------------------------------------------------------------------
module multi_edge_sync #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 1,
    parameter int CNT_W       = 8
) (
    input  logic                      rd_clk,
    input  logic                      rd_reset,
    input  logic [CHANNELS-1:0]       async_in,
    input  logic [2*CHANNELS-1:0]     edge_mode,
    input  logic [CHANNELS-1:0]       cnt_clr,
    output logic [CHANNELS-1:0]       level_o,
    output logic [CHANNELS-1:0]       rise_o,
    output logic [CHANNELS-1:0]       fall_o,
    output logic [CHANNELS-1:0]       event_o,
    output logic [CHANNELS*CNT_W-1:0] evt_cnt_o,
    output logic [CHANNELS-1:0]       overflow_o
);

    localparam int                FCNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
        logic                   level_q, level_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   ovf_q, ovf_d;
        logic                   evt;

        assign s = sync_q[SYNC_STAGES-1];

        // fcnt counts consecutive edges on which the synced value disagrees
        // with the accepted level; any agreement restarts the window.
        always_comb begin
            fcnt_d  = fcnt_q;
            level_d = level_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (s == level_q) begin
                fcnt_d = '0;
            end else if (fcnt_q == FCNT_LAST) begin
                level_d = s;
                fcnt_d  = '0;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end

        assign evt = (rise_q & edge_mode[2*c]) | (fall_q & edge_mode[2*c+1]);

        always_comb begin
            cnt_d = cnt_q;
            ovf_d = ovf_q;
            if (cnt_clr[c]) begin
                // A clear coinciding with an event keeps that event.
                cnt_d = evt ? CNT_W'(1) : '0;
                ovf_d = 1'b0;
            end else if (evt) begin
                if (cnt_q == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge rd_clk or negedge rd_reset) begin
            if (!rd_reset) begin
                sync_q  <= '0;
                fcnt_q  <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in[c]};
                fcnt_q  <= fcnt_d;
                level_q <= level_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
                cnt_q   <= cnt_d;
                ovf_q   <= ovf_d;
            end
        end

        assign level_o[c]                 = level_q;
        assign rise_o[c]                  = rise_q;
        assign fall_o[c]                  = fall_q;
        assign event_o[c]                 = evt;
        assign evt_cnt_o[c*CNT_W +: CNT_W] = cnt_q;
        assign overflow_o[c]              = ovf_q;
    end

endmodule
